// File: rtl/pkt_id_pkg.sv
// pkt_id_pkg: shared byte-class codes, sync-header codes, framer state and buffer entry types.
package pkt_id_pkg;

    // One-hot byte class codes from the byte checker; 0 means idle/skip.
    localparam logic [5:0] T_STP       = 6'b000001;
    localparam logic [5:0] T_SDP       = 6'b000010;
    localparam logic [5:0] T_TLP_DATA  = 6'b000100;
    localparam logic [5:0] T_DLLP_DATA = 6'b001000;
    localparam logic [5:0] T_END       = 6'b010000;
    localparam logic [5:0] T_EDB       = 6'b100000;

    // Gen3 block sync headers (data block / ordered-set block).
    localparam logic [1:0] SYNC_DATA   = 2'b10;
    localparam logic [1:0] SYNC_ORDSET = 2'b01;

    typedef enum logic [1:0] {IDLE, IN_TLP, IN_DLLP, DISCARD} state_e;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       is_dllp;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: byte buffer whose read side only sees bytes up to the commit pointer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   wr_en_i        write wr_entry_i at wr_ptr
//   commit_i       publish everything written so far (including a same-cycle write)
//   rewind_i       discard uncommitted bytes (wr_ptr <- commit_ptr)
//   rd_en_i        consumer pops the entry at rd_ptr when valid_o
//   rd_entry_o     entry at rd_ptr
//   full_o         DEPTH entries between rd_ptr and wr_ptr
//   valid_o        committed, unread data present
module commit_fifo
    import pkt_id_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   wr_en_i,
    input  entry_t wr_entry_i,
    input  logic   commit_i,
    input  logic   rewind_i,
    input  logic   rd_en_i,
    output entry_t rd_entry_o,
    output logic   full_o,
    output logic   valid_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, commit_q, rd_q;
    entry_t      mem_q [DEPTH];

    always_ff @(posedge clk)
        if (wr_en_i) mem_q[wr_q[AW-1:0]] <= wr_entry_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= '0;
            commit_q <= '0;
            rd_q     <= '0;
        end else begin
            if (wr_en_i) wr_q <= wr_q + (AW+1)'(1);
            else if (rewind_i) wr_q <= commit_q;
            if (commit_i) commit_q <= wr_q + {{AW{1'b0}}, wr_en_i};
            if (rd_en_i && valid_o) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    assign full_o     = (wr_q - rd_q) == (AW+1)'(DEPTH);
    assign valid_o    = rd_q != commit_q;
    assign rd_entry_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/pkt_framer_buffer.sv
// pkt_framer_buffer: frames TLP/DLLP packets from the classified byte stream and releases them after a good END.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid, in_data, in_type classified byte input
//   out_valid, out_ready       output handshake
//   out_data, out_sop, out_eop, out_is_dllp  committed packet bytes
//   drop_pulse                 packet discarded
//   overflow_pulse             packet discarded for full buffer or MAX_LEN
//   err_pulse                  stray byte outside a packet
module pkt_framer_buffer
    import pkt_id_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int MAX_LEN  = 48,
    parameter int DLLP_LEN = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [5:0] in_type,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_is_dllp,
    output logic       drop_pulse,
    output logic       overflow_pulse,
    output logic       err_pulse
);
    localparam int CW = $clog2(DEPTH) + 2;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    stg_q, stg_d;
    logic          drop_q, drop_d, ovf_q, ovf_d, err_q, err_d;
    logic          wr_en, commit, rewind, eop_w, full, fifo_valid;
    logic          in_pkt, is_start, data_ok, tlp_too_long, end_ok;
    entry_t        rd_entry;

    assign in_pkt       = (state_q == IN_TLP) || (state_q == IN_DLLP);
    assign is_start     = (in_type == T_STP) || (in_type == T_SDP);
    assign data_ok      = (state_q == IN_TLP) ? (in_type == T_TLP_DATA) : (in_type == T_DLLP_DATA);
    assign tlp_too_long = (state_q == IN_TLP) && (cnt_q >= CW'(MAX_LEN));
    assign end_ok       = (in_type == T_END) && (cnt_q != '0) &&
                          ((state_q == IN_TLP) || (cnt_q == CW'(DLLP_LEN)));

    // The byte in stg_q is the newest payload byte; it is only written once the
    // next data byte or END arrives, so END can tag it with eop. cnt_q==1 at
    // write time means the staged byte is the packet's first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        eop_w   = 1'b0;
        rewind  = 1'b0;
        drop_d  = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        if (in_valid) begin
            if (is_start) begin
                rewind  = in_pkt;
                drop_d  = in_pkt;
                state_d = (in_type == T_STP) ? IN_TLP : IN_DLLP;
                cnt_d   = '0;
            end else if (state_q == IDLE) begin
                err_d = in_type inside {T_TLP_DATA, T_DLLP_DATA, T_END, T_EDB};
            end else if (state_q == DISCARD) begin
                if (in_type inside {T_END, T_EDB}) state_d = IDLE;
            end else if (data_ok) begin
                if (tlp_too_long || (cnt_q != '0 && full)) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en = cnt_q != '0;
                    stg_d = in_data;
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (end_ok) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    eop_w   = 1'b1;
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end else if (in_type != '0) begin
                drop_d  = 1'b1;
                rewind  = 1'b1;
                state_d = IDLE;
            end
            if (ovf_d) begin
                drop_d  = 1'b1;
                rewind  = 1'b1;
                state_d = DISCARD;
            end
            if (rewind) begin
                stg_d = '0;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stg_q   <= '0;
            drop_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_entry_i('{sop: cnt_q == CW'(1), eop: eop_w, is_dllp: state_q == IN_DLLP, data: stg_q}),
        .commit_i  (commit),
        .rewind_i  (rewind),
        .rd_en_i   (out_ready),
        .rd_entry_o(rd_entry),
        .full_o    (full),
        .valid_o   (fifo_valid)
    );

    // Memory is not reset, so fields are forced to 0 whenever nothing is committed.
    assign out_valid      = fifo_valid;
    assign out_data       = fifo_valid ? rd_entry.data : '0;
    assign out_sop        = fifo_valid & rd_entry.sop;
    assign out_eop        = fifo_valid & rd_entry.eop;
    assign out_is_dllp    = fifo_valid & rd_entry.is_dllp;
    assign drop_pulse     = drop_q;
    assign overflow_pulse = ovf_q;
    assign err_pulse      = err_q;

endmodule

// File: tb/tb_pkt_framer_buffer.sv
// tb_pkt_framer_buffer: table-driven, directed and random checks of pkt_framer_buffer against a queue model.
module tb_pkt_framer_buffer;
    import pkt_id_pkg::*;

    localparam int DEPTH = 16, MAX_LEN = 16, DLLP_LEN = 6;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic [5:0] in_type = '0;
    logic       out_valid, out_sop, out_eop, out_is_dllp, drop_pulse, overflow_pulse, err_pulse;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    pkt_framer_buffer #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .DLLP_LEN(DLLP_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_type(in_type),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .out_is_dllp(out_is_dllp), .drop_pulse(drop_pulse),
        .overflow_pulse(overflow_pulse), .err_pulse(err_pulse)
    );

    typedef struct packed {logic sop; logic eop; logic k; logic [7:0] d;} ent_t;
    typedef struct packed {logic [5:0] t; logic [7:0] d; logic [14:0] exp;} vec_t;

    // Model: packets as byte lists; out_q holds committed, unread bytes.
    ent_t       out_q[$];
    logic [7:0] cur[$];
    int         mode;  // 0 idle, 1 tlp, 2 dllp, 3 discard
    logic       e_drop, e_ovf, e_err;
    int         checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] dut_vec();
        return {out_valid, out_sop, out_eop, out_is_dllp, out_data, drop_pulse, overflow_pulse, err_pulse};
    endfunction

    function automatic logic [14:0] model_vec();
        ent_t h;
        h = (out_q.size() != 0) ? out_q[0] : '0;
        return {out_q.size() != 0, h.sop, h.eop, h.k, h.d, e_drop, e_ovf, e_err};
    endfunction

    function automatic logic [14:0] ev(input logic v, s, e, k, input logic [7:0] d, input logic dr, ov, er);
        return {v, s, e, k, d, dr, ov, er};
    endfunction

    task automatic model_reset();
        out_q.delete(); cur.delete(); mode = 0;
        e_drop = 0; e_ovf = 0; e_err = 0;
    endtask

    task automatic model_edge(input logic v, input logic [5:0] t, input logic [7:0] d, input logic r);
        int  pend;
        bit  full, tlp, ovf;
        pend = (cur.size() > 0) ? cur.size() - 1 : 0;
        full = (out_q.size() + pend) >= DEPTH;
        e_drop = 0; e_ovf = 0; e_err = 0; ovf = 0;
        if (r && out_q.size() != 0) void'(out_q.pop_front());
        if (!v) return;
        tlp = (mode == 1);
        if (t == T_STP || t == T_SDP) begin
            e_drop = (mode == 1 || mode == 2);
            cur.delete();
            mode = (t == T_STP) ? 1 : 2;
        end else if (mode == 0) begin
            e_err = (t == T_TLP_DATA || t == T_DLLP_DATA || t == T_END || t == T_EDB);
        end else if (mode == 3) begin
            if (t == T_END || t == T_EDB) mode = 0;
        end else if (t == (tlp ? T_TLP_DATA : T_DLLP_DATA)) begin
            if ((tlp && cur.size() + 1 > MAX_LEN) || (cur.size() > 0 && full)) ovf = 1;
            else cur.push_back(d);
        end else if (t == T_END && cur.size() > 0 && (tlp || cur.size() == DLLP_LEN)) begin
            if (full) ovf = 1;
            else begin
                foreach (cur[i]) out_q.push_back('{i == 0, i == cur.size() - 1, !tlp, cur[i]});
                cur.delete();
                mode = 0;
            end
        end else if (t != 0) begin
            e_drop = 1; cur.delete(); mode = 0;
        end
        if (ovf) begin
            e_drop = 1; e_ovf = 1; cur.delete(); mode = 3;
        end
    endtask

    task automatic step(input logic v, input logic [5:0] t, input logic [7:0] d, input logic r);
        in_valid = v; in_type = t; in_data = d; out_ready = r;
        model_edge(v, t, d, r);
        @(posedge clk); #1;
        chk("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic drain(output int got);
        got = 0;
        for (int i = 0; i < 64 && (out_q.size() != 0 || out_valid); i++) begin
            if (out_valid) got++;
            step(0, 0, 0, 1);
        end
        chk("drain_empty", {31'd0, out_valid}, 0);
    endtask

    vec_t tbl[$];
    int   got;

    initial begin
        model_reset();
        #12;
        chk("reset_state", 32'(dut_vec()), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // TLP framing, DLLP good/short length, stray bytes in IDLE
        tbl.push_back('{T_STP, 8'h00, 15'd0});
        for (int i = 1; i <= 3; i++) tbl.push_back('{T_TLP_DATA, 8'(i), 15'd0});
        tbl.push_back('{T_END, 8'h00, ev(1, 1, 0, 0, 8'h01, 0, 0, 0)});
        tbl.push_back('{6'd0, 8'h00, ev(1, 0, 0, 0, 8'h02, 0, 0, 0)});
        tbl.push_back('{6'd0, 8'h00, ev(1, 0, 1, 0, 8'h03, 0, 0, 0)});
        tbl.push_back('{6'd0, 8'h00, 15'd0});
        tbl.push_back('{T_SDP, 8'h00, 15'd0});
        for (int i = 0; i < 6; i++) tbl.push_back('{T_DLLP_DATA, 8'(8'hA0 + i), 15'd0});
        tbl.push_back('{T_END, 8'h00, ev(1, 1, 0, 1, 8'hA0, 0, 0, 0)});
        for (int i = 1; i < 6; i++) tbl.push_back('{6'd0, 8'h00, ev(1, 0, i == 5, 1, 8'(8'hA0 + i), 0, 0, 0)});
        tbl.push_back('{6'd0, 8'h00, 15'd0});
        tbl.push_back('{T_SDP, 8'h00, 15'd0});
        for (int i = 0; i < 5; i++) tbl.push_back('{T_DLLP_DATA, 8'(8'hB0 + i), 15'd0});
        tbl.push_back('{T_END, 8'h00, ev(0, 0, 0, 0, 8'h00, 1, 0, 0)});
        tbl.push_back('{T_TLP_DATA, 8'h55, ev(0, 0, 0, 0, 8'h00, 0, 0, 1)});
        tbl.push_back('{T_END, 8'h00, ev(0, 0, 0, 0, 8'h00, 0, 0, 1)});
        foreach (tbl[i]) begin
            step(1, tbl[i].t, tbl[i].d, 1);
            chk($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end

        // Nullified TLP behind a committed one
        step(1, T_STP, 0, 0);
        for (int i = 0; i < 3; i++) step(1, T_TLP_DATA, 8'(8'h10 + i), 0);
        step(1, T_END, 0, 0);
        step(1, T_STP, 0, 0);
        for (int i = 0; i < 4; i++) step(1, T_TLP_DATA, 8'(8'h20 + i), 0);
        step(1, T_EDB, 0, 0);
        chk("edb_drop", {31'd0, drop_pulse}, 1);
        drain(got);
        chk("edb_first_kept", got, 3);

        // MAX_LEN overflow, DISCARD until END, then recovery
        step(1, T_STP, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(1, T_TLP_DATA, 8'(i), 0);
            if (i == 16) chk("no_ovf_16", {30'd0, drop_pulse, overflow_pulse}, 0);
            if (i == 17) chk("ovf_17", {30'd0, drop_pulse, overflow_pulse}, 3);
        end
        step(1, T_END, 0, 0);
        chk("discard_end_quiet", {29'd0, drop_pulse, overflow_pulse, err_pulse}, 0);
        step(1, T_STP, 0, 0);
        for (int i = 0; i < 4; i++) step(1, T_TLP_DATA, 8'(8'hC0 + i), 0);
        step(1, T_END, 0, 0);
        step(0, 0, 0, 0);
        chk("recover_head", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hC0});
        drain(got);
        chk("recover_count", got, 4);

        // Full-buffer overflow: 10 committed bytes unread, next packet fills to DEPTH
        step(1, T_STP, 0, 0);
        for (int i = 0; i < 10; i++) step(1, T_TLP_DATA, 8'(8'h40 + i), 0);
        step(1, T_END, 0, 0);
        step(1, T_STP, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, T_TLP_DATA, 8'(8'h60 + i), 0);
            if (i == 7) chk("no_full_7", {31'd0, overflow_pulse}, 0);
            if (i == 8) chk("full_ovf_8", {31'd0, overflow_pulse}, 1);
        end
        step(1, T_EDB, 0, 0);
        drain(got);
        chk("full_first_kept", got, 10);

        // SDP aborts a TLP and starts a DLLP in the same cycle
        step(1, T_STP, 0, 1);
        step(1, T_TLP_DATA, 8'h71, 1);
        step(1, T_TLP_DATA, 8'h72, 1);
        step(1, T_SDP, 0, 1);
        chk("sdp_abort_drop", {31'd0, drop_pulse}, 1);
        for (int i = 0; i < 6; i++) step(1, T_DLLP_DATA, 8'(8'h80 + i), 0);
        step(1, T_END, 0, 0);
        chk("abort_dllp_head", {20'd0, out_valid, out_sop, out_is_dllp, 1'b0, out_data}, {20'd0, 3'b111, 1'b0, 8'h80});
        drain(got);
        chk("abort_dllp_count", got, 6);

        // Asynchronous reset mid-packet
        step(1, T_STP, 0, 0);
        for (int i = 0; i < 3; i++) step(1, T_TLP_DATA, 8'(8'h90 + i), 0);
        #3 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("reset_async", 32'(dut_vec()), 0);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step(1, T_END, 0, 1);
        chk("reset_end_is_stray", {31'd0, err_pulse}, 1);
        step(1, T_STP, 0, 1);
        step(1, T_TLP_DATA, 8'hD1, 1);
        step(1, T_TLP_DATA, 8'hD2, 1);
        step(1, T_END, 0, 1);
        drain(got);
        chk("reset_recover_count", got, 2);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int         p;
            logic [5:0] t;
            logic       r;
            p = $urandom_range(0, 99);
            if (p < 55) t = (mode == 2) ? T_DLLP_DATA : T_TLP_DATA;
            else if (p < 65) t = T_END;
            else if (p < 68) t = T_EDB;
            else if (p < 74) t = T_STP;
            else if (p < 79) t = T_SDP;
            else if (p < 90) t = 6'd0;
            else t = (mode == 2) ? T_TLP_DATA : T_DLLP_DATA;
            if (mode == 2 && cur.size() == DLLP_LEN && $urandom_range(0, 1) == 1) t = T_END;
            r = ((c / 50) % 3 == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 7) != 0, t, 8'($urandom), r);
        end
        drain(got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
